// File: rtl/register_bank_pkg.sv
// Shared types and default widths for the multi-port register bank.
package register_bank_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } bank_state_e;

  function automatic int depth_of(input int addr_width);
    return 32'sd1 << addr_width;
  endfunction

endpackage

// File: rtl/register_bank_mp_if.sv
// Decode/writeback side bus of the register bank: read ports, write port, reservation.
interface register_bank_mp_if
  import register_bank_pkg::*;
#(
  parameter int DATA_WIDTH = XLEN,
  parameter int ADDR_WIDTH = REG_ADDR_W,
  parameter int NUM_READ   = 2
);

  logic [NUM_READ*ADDR_WIDTH-1:0] read_register_addr;
  logic [NUM_READ*DATA_WIDTH-1:0] read_data;
  logic [NUM_READ-1:0]            read_busy;
  logic [ADDR_WIDTH-1:0]          write_register_addr;
  logic [DATA_WIDTH-1:0]          write_data;
  logic                           write_enable;
  logic                           reserve_enable;
  logic [ADDR_WIDTH-1:0]          reserve_addr;
  logic                           ready;

  modport master (
    output read_register_addr, write_register_addr, write_data, write_enable,
    output reserve_enable, reserve_addr,
    input  read_data, read_busy, ready
  );

  modport slave (
    input  read_register_addr, write_register_addr, write_data, write_enable,
    input  reserve_enable, reserve_addr,
    output read_data, read_busy, ready
  );

endinterface

// File: rtl/register_scoreboard.sv
// Per-register busy bits for outstanding writebacks; a reservation beats a same-cycle writeback.
module register_scoreboard
  import register_bank_pkg::*;
#(
  parameter int ADDR_WIDTH = REG_ADDR_W,
  parameter int NUM_READ   = 2,
  parameter int ZERO_REG   = 1,
  parameter int BYPASS     = 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           i_active,
  input  logic                           i_set_en,
  input  logic [ADDR_WIDTH-1:0]          i_set_addr,
  input  logic                           i_clr_en,
  input  logic [ADDR_WIDTH-1:0]          i_clr_addr,
  input  logic [NUM_READ*ADDR_WIDTH-1:0] i_rd_addr,
  output logic [NUM_READ-1:0]            o_rd_busy
);

  localparam int DEPTH = depth_of(ADDR_WIDTH);
  localparam logic [DEPTH-1:0] HARD_ZERO_MASK =
    (ZERO_REG != 0) ? DEPTH'(1) : {DEPTH{1'b0}};

  logic [DEPTH-1:0] r_busy;
  logic [DEPTH-1:0] w_busy_upd;
  logic [DEPTH-1:0] w_busy_nxt;

  // Clear first, then set, so a newer producer keeps the register busy.
  always_comb begin
    w_busy_upd = r_busy;
    if (i_clr_en) begin
      w_busy_upd[i_clr_addr] = 1'b0;
    end else begin
      w_busy_upd = r_busy;
    end
    if (i_set_en) begin
      w_busy_upd[i_set_addr] = 1'b1;
    end else begin
      w_busy_upd[i_set_addr] = w_busy_upd[i_set_addr];
    end
  end

  assign w_busy_nxt = w_busy_upd & ~HARD_ZERO_MASK;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy <= {DEPTH{1'b0}};
    end else begin
      r_busy <= w_busy_nxt;
    end
  end

  for (genvar g = 0; g < NUM_READ; g++) begin : g_port
    logic [ADDR_WIDTH-1:0] w_addr;
    logic                  w_fwd_clr;
    assign w_addr    = i_rd_addr[g*ADDR_WIDTH +: ADDR_WIDTH];
    assign w_fwd_clr = (BYPASS != 0) && i_clr_en && (i_clr_addr == w_addr) &&
                       !(i_set_en && (i_set_addr == w_addr));
    assign o_rd_busy[g] = i_active && r_busy[w_addr] && !w_fwd_clr;
  end

endmodule

// File: rtl/register_bank_mp.sv
// Multi-read-port register bank: hardware clear sweep after reset, write bypass and RAW scoreboard.
module register_bank_mp
  import register_bank_pkg::*;
#(
  parameter int DATA_WIDTH = XLEN,
  parameter int ADDR_WIDTH = REG_ADDR_W,
  parameter int NUM_READ   = 2,
  parameter int ZERO_REG   = 1,
  parameter int BYPASS     = 1
) (
  input  logic              clk,
  input  logic              rst,
  register_bank_mp_if.slave bus
);

  localparam int DEPTH = depth_of(ADDR_WIDTH);
  localparam logic [ADDR_WIDTH:0] LAST_IDX = (ADDR_WIDTH+1)'(DEPTH - 1);
  localparam logic [ADDR_WIDTH:0] CNT_ONE  = (ADDR_WIDTH+1)'(1);

  bank_state_e           r_state;
  bank_state_e           w_state_nxt;
  logic [ADDR_WIDTH:0]   r_clr_cnt;
  logic [ADDR_WIDTH:0]   w_clr_cnt_nxt;
  logic                  w_clr_we;
  logic                  w_active;
  logic                  w_usr_we;
  logic                  w_wr_nonzero;
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  assign w_active     = (r_state == READY);
  assign w_wr_nonzero = (ZERO_REG == 0) || (bus.write_register_addr != {ADDR_WIDTH{1'b0}});
  assign w_usr_we     = w_active && !rst && bus.write_enable && w_wr_nonzero;
  assign bus.ready    = w_active;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= CLEAR;
      r_clr_cnt <= {(ADDR_WIDTH+1){1'b0}};
    end else begin
      r_state   <= w_state_nxt;
      r_clr_cnt <= w_clr_cnt_nxt;
    end
  end

  // Sweep zeroes one entry per cycle and hands over to READY after the last one.
  always_comb begin
    w_state_nxt   = r_state;
    w_clr_cnt_nxt = r_clr_cnt;
    w_clr_we      = 1'b0;
    case (r_state)
      CLEAR: begin
        w_clr_we      = 1'b1;
        w_clr_cnt_nxt = r_clr_cnt + CNT_ONE;
        if (r_clr_cnt == LAST_IDX) begin
          w_state_nxt = READY;
        end else begin
          w_state_nxt = CLEAR;
        end
      end
      READY: begin
        w_state_nxt   = READY;
        w_clr_cnt_nxt = r_clr_cnt;
      end
      default: begin
        w_state_nxt   = CLEAR;
        w_clr_cnt_nxt = {(ADDR_WIDTH+1){1'b0}};
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_clr_we) begin
      r_mem[r_clr_cnt[ADDR_WIDTH-1:0]] <= {DATA_WIDTH{1'b0}};
    end else if (w_usr_we) begin
      r_mem[bus.write_register_addr] <= bus.write_data;
    end
  end

  for (genvar g = 0; g < NUM_READ; g++) begin : g_read
    logic [ADDR_WIDTH-1:0] w_addr;
    logic                  w_zero_hit;
    logic                  w_byp_hit;
    assign w_addr     = bus.read_register_addr[g*ADDR_WIDTH +: ADDR_WIDTH];
    assign w_zero_hit = (ZERO_REG != 0) && (w_addr == {ADDR_WIDTH{1'b0}});
    assign w_byp_hit  = (BYPASS != 0) && bus.write_enable &&
                        (bus.write_register_addr == w_addr);
    assign bus.read_data[g*DATA_WIDTH +: DATA_WIDTH] =
      (!w_active || w_zero_hit) ? {DATA_WIDTH{1'b0}} :
      w_byp_hit                 ? bus.write_data     : r_mem[w_addr];
  end

  register_scoreboard #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .NUM_READ   (NUM_READ),
    .ZERO_REG   (ZERO_REG),
    .BYPASS     (BYPASS)
  ) u_scoreboard (
    .clk        (clk),
    .rst        (rst),
    .i_active   (w_active),
    .i_set_en   (w_active && bus.reserve_enable),
    .i_set_addr (bus.reserve_addr),
    .i_clr_en   (w_active && bus.write_enable),
    .i_clr_addr (bus.write_register_addr),
    .i_rd_addr  (bus.read_register_addr),
    .o_rd_busy  (bus.read_busy)
  );

endmodule

// File: tb/tb_register_bank_mp.sv
// Directed plus random checks of three bank configurations against an array-based reference model.
module tb_register_bank_mp;
  import register_bank_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  register_bank_mp_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .NUM_READ(2)) bus_a ();
  register_bank_mp_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .NUM_READ(2)) bus_b ();
  register_bank_mp_if #(.DATA_WIDTH(64), .ADDR_WIDTH(4), .NUM_READ(3)) bus_c ();

  register_bank_mp #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .NUM_READ(2), .ZERO_REG(1), .BYPASS(1))
    dut_a (.clk(clk), .rst(rst), .bus(bus_a));
  register_bank_mp #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .NUM_READ(2), .ZERO_REG(1), .BYPASS(0))
    dut_b (.clk(clk), .rst(rst), .bus(bus_b));
  register_bank_mp #(.DATA_WIDTH(64), .ADDR_WIDTH(4), .NUM_READ(3), .ZERO_REG(1), .BYPASS(1))
    dut_c (.clk(clk), .rst(rst), .bus(bus_c));

  // Reference model of configuration A: architectural contents, busy set, readiness.
  logic [31:0] m_mem [32];
  bit          m_busy [32];
  bit          m_ready = 1'b0;
  int          m_sweep = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    if (rst) begin
      m_ready = 1'b0;
      m_sweep = 0;
      for (int r = 0; r < 32; r++) begin
        m_mem[r]  = 32'h0;
        m_busy[r] = 1'b0;
      end
    end else if (!m_ready) begin
      m_sweep++;
      if (m_sweep == 32) m_ready = 1'b1;
    end else begin
      if (bus_a.write_enable) begin
        if (bus_a.write_register_addr != 5'd0) m_mem[bus_a.write_register_addr] = bus_a.write_data;
        m_busy[bus_a.write_register_addr] = 1'b0;
      end
      if (bus_a.reserve_enable && bus_a.reserve_addr != 5'd0) m_busy[bus_a.reserve_addr] = 1'b1;
    end
  endtask

  task automatic drive_a(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                         input logic re, input logic [4:0] ra,
                         input logic [4:0] ra0, input logic [4:0] ra1);
    bus_a.write_enable        = we;
    bus_a.write_register_addr = wa;
    bus_a.write_data          = wd;
    bus_a.reserve_enable      = re;
    bus_a.reserve_addr        = ra;
    bus_a.read_register_addr  = {ra1, ra0};
  endtask

  task automatic check_a(input string tag);
    logic [4:0]  a;
    logic [31:0] e_rd;
    logic        e_bz;
    for (int i = 0; i < 2; i++) begin
      a = bus_a.read_register_addr[i*5 +: 5];
      if (!m_ready || a == 5'd0) e_rd = 32'h0;
      else if (bus_a.write_enable && bus_a.write_register_addr == a) e_rd = bus_a.write_data;
      else e_rd = m_mem[a];
      if (!m_ready) e_bz = 1'b0;
      else if (bus_a.write_enable && bus_a.write_register_addr == a &&
               !(bus_a.reserve_enable && bus_a.reserve_addr == a)) e_bz = 1'b0;
      else e_bz = m_busy[a];
      check($sformatf("%s_rd%0d_x%0d", tag, i, a), {32'h0, bus_a.read_data[i*32 +: 32]}, {32'h0, e_rd});
      check($sformatf("%s_busy%0d_x%0d", tag, i, a), {63'h0, bus_a.read_busy[i]}, {63'h0, e_bz});
    end
    check({tag, "_ready"}, {63'h0, bus_a.ready}, {63'h0, m_ready});
  endtask

  task automatic cycle_a(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                         input logic re, input logic [4:0] ra,
                         input logic [4:0] ra0, input logic [4:0] ra1, input string tag);
    drive_a(we, wa, wd, re, ra, ra0, ra1);
    @(negedge clk);
    check_a(tag);
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  initial begin
    drive_a(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0);
    bus_b.write_enable = 1'b0; bus_b.write_register_addr = 5'd0; bus_b.write_data = 32'h0;
    bus_b.reserve_enable = 1'b0; bus_b.reserve_addr = 5'd0; bus_b.read_register_addr = 10'd0;
    bus_c.write_enable = 1'b0; bus_c.write_register_addr = 4'd0; bus_c.write_data = 64'h0;
    bus_c.reserve_enable = 1'b0; bus_c.reserve_addr = 4'd0; bus_c.read_register_addr = 12'd0;
    rst = 1'b1;
    tick();

    // Reset state, then the sweep: writes/reserves are ignored, ready after exactly DEPTH cycles.
    cycle_a(1'b1, 5'd5, 32'hFFFF_FFFF, 1'b1, 5'd6, 5'd5, 5'd6, "rst");
    check("rst_ready_c", {63'h0, bus_c.ready}, 64'h0);
    tick();
    rst = 1'b0;
    for (int k = 1; k <= 33; k++) begin
      cycle_a(1'b1, 5'd5, 32'hFFFF_FFFF, 1'b1, 5'd6, 5'd5, 5'd6, "sweep");
      check($sformatf("sweep_ready_c_%0d", k), {63'h0, bus_c.ready}, {63'h0, (k - 1 >= 16)});
      if (k <= 32) begin
        check($sformatf("sweep_ready_a_%0d", k), {63'h0, bus_a.ready}, {63'h0, (k - 1 >= 32)});
        tick();
      end
    end
    for (int r = 0; r < 16; r++) begin
      cycle_a(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'(2*r), 5'(2*r+1), "clr");
      check($sformatf("clr_zero_%0d", 2*r), {32'h0, bus_a.read_data[31:0]}, 64'h0);
      tick();
    end

    // Write/read and the hardwired zero register.
    cycle_a(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 5'd1, 5'd2, "t2_wr"); tick();
    cycle_a(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd5, 5'd5, "t2_rd");
    check("t2_x5_p1", {32'h0, bus_a.read_data[63:32]}, 64'hDEADBEEF);
    tick();
    cycle_a(1'b1, 5'd0, 32'h12345678, 1'b0, 5'd0, 5'd0, 5'd5, "t2_wr0"); tick();
    cycle_a(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0, "t2_rd0");
    check("t2_x0_p0", {32'h0, bus_a.read_data[31:0]}, 64'h0);
    tick();

    // Bypass on A; no bypass on B (old value same cycle, new value next cycle).
    bus_b.write_enable = 1'b1; bus_b.write_register_addr = 5'd7; bus_b.write_data = 32'h1111_1111;
    cycle_a(1'b1, 5'd7, 32'hCAFEF00D, 1'b0, 5'd0, 5'd1, 5'd7, "t3_byp");
    check("t3_a_bypass", {32'h0, bus_a.read_data[63:32]}, 64'hCAFEF00D);
    tick();
    bus_b.write_data = 32'hCAFEF00D; bus_b.read_register_addr = {5'd7, 5'd0};
    bus_b.reserve_enable = 1'b1; bus_b.reserve_addr = 5'd4;
    cycle_a(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd7, 5'd7, "t3_a_rd");
    check("t3_b_old", {32'h0, bus_b.read_data[63:32]}, 64'h1111_1111);
    tick();
    bus_b.write_enable = 1'b1; bus_b.write_register_addr = 5'd4; bus_b.write_data = 32'h4444_4444;
    bus_b.reserve_enable = 1'b0; bus_b.read_register_addr = {5'd7, 5'd4};
    cycle_a(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd7, 5'd7, "t3_a_rd2");
    check("t3_b_new", {32'h0, bus_b.read_data[63:32]}, 64'hCAFEF00D);
    check("t3_b_busy_nobyp", {63'h0, bus_b.read_busy[0]}, 64'h1);
    check("t3_b_old_x4", {32'h0, bus_b.read_data[31:0]}, 64'h0);
    tick();
    bus_b.write_enable = 1'b0;
    cycle_a(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd4, 5'd4, "t3_a_rd3");
    check("t3_b_busy_clr", {63'h0, bus_b.read_busy[0]}, 64'h0);
    check("t3_b_x4", {32'h0, bus_b.read_data[31:0]}, 64'h4444_4444);
    tick();

    // Scoreboard: reserve, writeback, same-cycle reserve+write, x0 never busy.
    cycle_a(1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 5'd3, 5'd0, "t4_res");
    check("t4_not_yet", {63'h0, bus_a.read_busy[0]}, 64'h0);
    tick();
    cycle_a(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd3, 5'd3, "t4_busy");
    check("t4_busy_x3", {63'h0, bus_a.read_busy[0]}, 64'h1);
    tick();
    cycle_a(1'b1, 5'd3, 32'h0000_0033, 1'b0, 5'd0, 5'd3, 5'd0, "t4_wb");
    check("t4_wb_bypass", {63'h0, bus_a.read_busy[0]}, 64'h0);
    tick();
    cycle_a(1'b1, 5'd3, 32'h0000_0034, 1'b1, 5'd3, 5'd3, 5'd3, "t4_both"); tick();
    cycle_a(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 5'd3, 5'd0, "t4_after");
    check("t4_set_wins", {63'h0, bus_a.read_busy[0]}, 64'h1);
    tick();
    cycle_a(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd3, "t4_x0");
    check("t4_x0_never", {63'h0, bus_a.read_busy[0]}, 64'h0);
    tick();

    // Configuration C: three 64-bit ports reading distinct entries.
    bus_c.write_enable = 1'b1;
    bus_c.write_register_addr = 4'd15; bus_c.write_data = 64'h0123_4567_89AB_CDEF; tick();
    bus_c.write_register_addr = 4'd1;  bus_c.write_data = 64'hFEDC_BA98_7654_3210; tick();
    bus_c.write_register_addr = 4'd2;  bus_c.write_data = 64'h5A5A_0000_FFFF_A5A5; tick();
    bus_c.write_enable = 1'b0; bus_c.read_register_addr = {4'd2, 4'd1, 4'd15};
    @(negedge clk);
    check("t6_c_p0", bus_c.read_data[63:0],    64'h0123_4567_89AB_CDEF);
    check("t6_c_p1", bus_c.read_data[127:64],  64'hFEDC_BA98_7654_3210);
    check("t6_c_p2", bus_c.read_data[191:128], 64'h5A5A_0000_FFFF_A5A5);
    tick();

    // Randomized traffic with address collisions.
    for (int n = 0; n < 300; n++) begin
      cycle_a(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
              1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
              5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), "rnd");
      tick();
    end

    // Reset mid-operation and again mid-sweep.
    cycle_a(1'b1, 5'd9, 32'hA5A5A5A5, 1'b1, 5'd9, 5'd9, 5'd9, "t5_wr"); tick();
    cycle_a(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd9, 5'd9, "t5_rd");
    check("t5_x9_busy", {63'h0, bus_a.read_busy[0]}, 64'h1);
    tick();
    rst = 1'b1;
    cycle_a(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd9, 5'd9, "t5_rst1"); tick();
    rst = 1'b0;
    for (int k = 0; k < 10; k++) begin
      cycle_a(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd9, 5'd9, "t5_sw1"); tick();
    end
    rst = 1'b1;
    cycle_a(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd9, 5'd9, "t5_rst2"); tick();
    rst = 1'b0;
    for (int k = 0; k <= 32; k++) begin
      cycle_a(1'b1, 5'd9, 32'h5A5A_5A5A, 1'b1, 5'd9, 5'd9, 5'd1, "t5_sw2");
      if (k < 32) tick();
    end
    check("t5_ready", {63'h0, bus_a.ready}, 64'h1);
    drive_a(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd9, 5'd9);
    #1;
    check("t5_x9_zero", {32'h0, bus_a.read_data[31:0]}, 64'h0);
    check("t5_x9_idle", {63'h0, bus_a.read_busy[0]}, 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/register_bank_mp.md
Name: register_bank_mp

Overview:
Parametrised multi-read-port register bank for the RISC-V core, successor to the fixed 2R1W 32x32 bank.
- Hardware-cleared on reset by an internal sweep; no file preload.
- Optional write-to-read bypass.
- Per-register busy scoreboard, so the pipelined core can detect RAW hazards on outstanding writebacks.
- Sits between decode (read/reserve) and writeback (write).

Parameters:
DATA_WIDTH, 32, bits per register
ADDR_WIDTH, 5, address bits; DEPTH = 2**ADDR_WIDTH registers
NUM_READ, 2, number of independent combinational read ports (1..4)
ZERO_REG, 1, 1 = register 0 hardwired to zero and never busy
BYPASS, 1, 1 = read of the address being written this cycle returns write_data

Ports:
clk  in  1  clock, all state updates on posedge
rst  in  1  synchronous active-high reset
read_register_addr  in  NUM_READ x ADDR_WIDTH  read addresses, packed, port i at slice i
read_data  out  NUM_READ x DATA_WIDTH  read data per port
read_busy  out  NUM_READ  1 = addressed register has a pending reservation
write_register_addr  in  ADDR_WIDTH  write address
write_data  in  DATA_WIDTH  write data
write_enable  in  1  write strobe; also clears busy of write_register_addr
reserve_enable  in  1  mark reserve_addr busy (issued instruction will write it)
reserve_addr  in  ADDR_WIDTH  register to reserve
ready  out  1  0 during clear sweep, 1 when bank is usable

Behaviour:
- Clock and reset: single clock clk; reset rst is synchronous, active-high.
- States: CLEAR, READY.
- On rst (sampled at posedge): state <= CLEAR, clear counter <= 0, all busy bits <= 0, ready <= 0. rst has priority over every other input.
- Reset mid-sweep restarts the sweep at entry 0.
- CLEAR:
  - Each cycle, write 0 to entry[counter], counter++.
  - When counter == DEPTH-1, that entry is cleared and state -> READY.
  - ready = 1 from the next cycle, i.e. exactly DEPTH cycles after rst deasserts.
  - write_enable and reserve_enable are ignored.
  - read_data = 0 and read_busy = 0 on all ports.
- READY writes:
  - write_enable=1 and (addr != 0 or ZERO_REG=0): entry <= write_data at posedge.
  - With ZERO_REG=1, a write to addr 0 is dropped.
- READY reads:
  - Combinational, zero latency: read_data[i] = entry[read_register_addr[i]].
  - ZERO_REG=1 and addr 0 -> 0.
  - BYPASS=1 and write_enable and address match (nonzero when ZERO_REG) -> write_data in the same cycle.
  - Multiple ports may read the same address.
- Scoreboard:
  - reserve_enable sets busy[reserve_addr].
  - write_enable clears busy[write_register_addr].
  - Same address, same cycle, both events: set wins (a newer producer supersedes).
  - ZERO_REG=1: busy[0] is always 0.
  - Reserving an already-busy register keeps it busy (no counting).
- read_busy:
  - read_busy[i] = busy[addr_i], registered state, no bypass.
  - Exception: with BYPASS=1, a same-cycle write to addr_i with no same-cycle reserve of addr_i forces read_busy[i] = 0.
- Reset values: ready=0, read_busy=0, read_data=0 while in CLEAR.
- Width rules: no arithmetic on data. Counter is ADDR_WIDTH+1 bits so DEPTH is reachable without wrap.

Decomposition:
- Package register_bank_pkg holds: state enum {CLEAR, READY}, localparam function for DEPTH, and the default widths (XLEN=32, REG_ADDR_W=5).
- One sub-module, register_scoreboard: owns the busy vector, set/clear priority, and per-port busy lookup with bypass.
- Storage, clear sweep and read muxing stay in the top.

Test Plan:
1. Reset sweep: assert rst 1 cycle, release, then poll ready -> ready=0 for exactly 32 cycles, 1 on cycle 33. Afterwards every register reads 0x00000000.
2. Write/read: write 0xDEADBEEF to x5, next cycle read x5 on port 0 and port 1 -> both 0xDEADBEEF. Write 0x12345678 to x0 -> x0 still reads 0.
3. Bypass: in one cycle, write 0xCAFEF00D to x7 while port 1 reads x7 -> read_data[1]=0xCAFEF00D same cycle. Repeat with BYPASS=0 -> old value; new value next cycle.
4. Scoreboard: reserve x3 -> read_busy=1 for x3 from the next cycle. Writeback x3 -> busy clears. Reserve and write x3 in the same cycle -> x3 stays busy. Reserve x0 -> never busy.
5. Reset mid-operation: write x9=0xA5A5A5A5, reserve x9, assert rst at sweep cycle 10 -> sweep restarts, ready after 32 more cycles, x9 reads 0, busy 0.
6. Parameter sweep: NUM_READ=3, ADDR_WIDTH=4, DATA_WIDTH=64 -> ready after 16 cycles. Three ports independently read distinct 64-bit values correctly.
